// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg : shared fetch-controller types, PCSrc codes and default reset PC
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DROP  = 2'd3
   } fetch_state_t;

   localparam logic [1:0]  PC_SEQ = 2'd0;
   localparam logic [1:0]  PC_BR  = 2'd1;
   localparam logic [1:0]  PC_J   = 2'd2;
   localparam logic [1:0]  PC_JR  = 2'd3;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

   function automatic logic [31:0] jump_target(input logic [3:0]  pc_hi,
                                               input logic [25:0] index);
      return {pc_hi, index, 2'b00};
   endfunction

endpackage

`default_nettype wire

// File: rtl/pc_next_sel.sv
// -----------------------------------------------------------------------------
// pc_next_sel : redirect priority (branch > jr > jump) and next-PC selection
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module pc_next_sel
   import cpu_pkg::*;
(
   input  logic [31:0] pc,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        j_valid,
   input  logic [25:0] j_index,
   input  logic [3:0]  id_pc_hi,
   input  logic        jr_valid,
   input  logic [31:0] jr_target,
   output logic        redirect,
   output logic [31:0] next_pc,
   output logic [1:0]  pc_src
);

   always_comb begin
      redirect = 1'b1;
      next_pc  = pc + 32'd4;
      pc_src   = PC_SEQ;
      if (br_taken) begin
         next_pc = br_target;
         pc_src  = PC_BR;
      end else if (jr_valid) begin
         next_pc = jr_target;
         pc_src  = PC_JR;
      end else if (j_valid) begin
         next_pc = jump_target(id_pc_hi, j_index);
         pc_src  = PC_J;
      end else begin
         redirect = 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl : PC owner and single-outstanding imem fetch sequencer to ID
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module pc_fetch_ctrl
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        br_taken_i,
   input  logic [31:0] br_target_i,
   input  logic        j_valid_i,
   input  logic [25:0] j_index_i,
   input  logic [3:0]  id_pc_hi_i,
   input  logic        jr_valid_i,
   input  logic [31:0] jr_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic        if_valid_o,
   input  logic        if_ready_i,
   output logic [31:0] if_instr_o,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_pc_plus4_o,
   output logic [1:0]  pc_src_o
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  req_addr;
   logic [31:0]  hold_instr;
   logic [31:0]  hold_pc;
   logic [31:0]  hold_pc4;
   logic [1:0]   pc_src_q;

   logic         sel_redirect;
   logic [31:0]  sel_next_pc;
   logic [1:0]   sel_src;
   logic         load_pc;

   pc_next_sel u_sel (
      .pc        (pc),
      .br_taken  (br_taken_i),
      .br_target (br_target_i),
      .j_valid   (j_valid_i),
      .j_index   (j_index_i),
      .id_pc_hi  (id_pc_hi_i),
      .jr_valid  (jr_valid_i),
      .jr_target (jr_target_i),
      .redirect  (sel_redirect),
      .next_pc   (sel_next_pc),
      .pc_src    (sel_src)
   );

   assign load_pc = sel_redirect || ((state == HOLD) && if_ready_i);

   // req_addr mirrors PC except in DROP, where the abandoned request must stay stable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         req_addr   <= RESET_PC;
         hold_instr <= 32'd0;
         hold_pc    <= 32'd0;
         hold_pc4   <= 32'd4;
         pc_src_q   <= PC_SEQ;
      end else begin
         if (load_pc) begin
            pc       <= sel_next_pc;
            pc_src_q <= sel_src;
         end
         case (state)
            IDLE: begin
               state <= FETCH;
               if (sel_redirect) req_addr <= sel_next_pc;
            end
            FETCH: begin
               if (imem_ack_i) begin
                  if (sel_redirect) begin
                     req_addr <= sel_next_pc;
                  end else begin
                     hold_instr <= imem_rdata_i;
                     hold_pc    <= pc;
                     hold_pc4   <= pc + 32'd4;
                     state      <= HOLD;
                  end
               end else if (sel_redirect) begin
                  state <= DROP;
               end
            end
            HOLD: begin
               if (load_pc) begin
                  req_addr <= sel_next_pc;
                  state    <= FETCH;
               end
            end
            DROP: begin
               if (imem_ack_i) begin
                  req_addr <= sel_redirect ? sel_next_pc : pc;
                  state    <= FETCH;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign imem_req_o    = (state == FETCH) || (state == DROP);
   assign imem_addr_o   = req_addr;
   assign if_valid_o    = (state == HOLD);
   assign if_instr_o    = hold_instr;
   assign if_pc_o       = hold_pc;
   assign if_pc_plus4_o = hold_pc4;
   assign pc_src_o      = pc_src_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_ctrl : scoreboard bench with a variable-latency imem model
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_pc_fetch_ctrl;

   localparam logic [31:0] DATA_KEY = 32'hDEAD_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        br_taken_i;
   logic [31:0] br_target_i;
   logic        j_valid_i;
   logic [25:0] j_index_i;
   logic [3:0]  id_pc_hi_i;
   logic        jr_valid_i;
   logic [31:0] jr_target_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_rdata_i;
   logic        if_valid_o;
   logic        if_ready_i;
   logic [31:0] if_instr_o;
   logic [31:0] if_pc_o;
   logic [31:0] if_pc_plus4_o;
   logic [1:0]  pc_src_o;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          lat     = 0;
   int          cnt     = 0;
   int          cyc     = 0;
   int          last_ack = 0;
   int          tp_n    = 0;
   bit          tp_on   = 1'b0;
   logic [31:0] xe;
   logic [31:0] exp_req_q[$];
   logic [31:0] exp_xfer_q[$];

   always #5 clk = ~clk;

   pc_fetch_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .br_taken_i    (br_taken_i),
      .br_target_i   (br_target_i),
      .j_valid_i     (j_valid_i),
      .j_index_i     (j_index_i),
      .id_pc_hi_i    (id_pc_hi_i),
      .jr_valid_i    (jr_valid_i),
      .jr_target_i   (jr_target_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ack_i    (imem_ack_i),
      .imem_rdata_i  (imem_rdata_i),
      .if_valid_o    (if_valid_o),
      .if_ready_i    (if_ready_i),
      .if_instr_o    (if_instr_o),
      .if_pc_o       (if_pc_o),
      .if_pc_plus4_o (if_pc_plus4_o),
      .pc_src_o      (pc_src_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // imem model (ack after lat extra req cycles) plus request and ID-side monitors
   always @(negedge clk) begin
      if (!rst_n) begin
         imem_ack_i = 1'b0;
         cnt        = 0;
      end else begin
         if (imem_req_o) begin
            if (cnt >= lat) begin
               imem_ack_i   = 1'b1;
               imem_rdata_i = imem_addr_o ^ DATA_KEY;
               cnt          = 0;
               if (exp_req_q.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL req_unexpected: got addr %h expected no request", imem_addr_o);
               end else begin
                  check("req_addr", imem_addr_o, exp_req_q.pop_front());
               end
               if (tp_on) begin
                  if (tp_n > 0) check("fetch_interval", 32'(cyc - last_ack), 32'd2);
                  tp_n++;
                  last_ack = cyc;
               end
            end else begin
               imem_ack_i = 1'b0;
               cnt++;
            end
         end else begin
            imem_ack_i = 1'b0;
         end
         if (if_valid_o && if_ready_i) begin
            if (exp_xfer_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL xfer_unexpected: got pc %h expected no transfer", if_pc_o);
            end else begin
               xe = exp_xfer_q.pop_front();
               check("xfer_pc", if_pc_o, xe);
               check("xfer_instr", if_instr_o, xe ^ DATA_KEY);
               check("xfer_pc4", if_pc_plus4_o, xe + 32'd4);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!if_valid_o && n < 40) begin
         step();
         n++;
      end
      if (!if_valid_o) begin
         n_tests++; n_fail++;
         $display("FAIL wait_valid_%s: got if_valid 0 expected 1 within 40 cycles", tag);
      end
   endtask

   task automatic clr();
      br_taken_i = 1'b0;
      j_valid_i  = 1'b0;
      jr_valid_i = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_req"},   {31'd0, imem_req_o}, 32'd0);
      check({tag, "_addr"},  imem_addr_o, 32'h0000_3000);
      check({tag, "_valid"}, {31'd0, if_valid_o}, 32'd0);
      check({tag, "_instr"}, if_instr_o, 32'd0);
      check({tag, "_pc"},    if_pc_o, 32'd0);
      check({tag, "_pc4"},   if_pc_plus4_o, 32'd4);
      check({tag, "_src"},   {30'd0, pc_src_o}, 32'd0);
   endtask

   task automatic chk_fetch(input string tag, input logic [31:0] addr, input logic [1:0] src);
      check({tag, "_addr"}, imem_addr_o, addr);
      check({tag, "_req"},  {31'd0, imem_req_o}, 32'd1);
      check({tag, "_src"},  {30'd0, pc_src_o}, {30'd0, src});
   endtask

   initial begin
      rst_n        = 1'b0;
      imem_ack_i   = 1'b0;
      imem_rdata_i = 32'd0;
      if_ready_i   = 1'b0;
      br_target_i  = 32'd0;
      jr_target_i  = 32'd0;
      j_index_i    = 26'd0;
      id_pc_hi_i   = 4'd0;
      clr();
      repeat (3) step();
      check_reset("por");

      // sequential stream, zero-wait imem
      tp_on = 1'b1;
      exp_req_q  = '{32'h3000, 32'h3004, 32'h3008, 32'h300C};
      exp_xfer_q = '{32'h3000, 32'h3004, 32'h3008};
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_valid("seq");
         if_ready_i = 1'b1;
         step();
         if_ready_i = 1'b0;
      end
      tp_on = 1'b0;

      // branch while HOLD and not ready drops held 300C
      exp_req_q.push_back(32'h3100);
      wait_valid("br");
      br_taken_i = 1'b1; br_target_i = 32'h3100;
      step(); clr();
      chk_fetch("br", 32'h3100, 2'd1);

      // priority: jr over j, branch over both, then j alone
      exp_req_q.push_back(32'h3200);
      exp_req_q.push_back(32'h3300);
      exp_req_q.push_back(32'h3100);
      exp_req_q.push_back(32'h3104);
      exp_xfer_q.push_back(32'h3100);
      wait_valid("jr_j");
      j_valid_i = 1'b1; j_index_i = 26'h0000C40; id_pc_hi_i = 4'h0;
      jr_valid_i = 1'b1; jr_target_i = 32'h3200;
      step(); clr();
      chk_fetch("jr_over_j", 32'h3200, 2'd3);
      wait_valid("br_all");
      br_taken_i = 1'b1; br_target_i = 32'h3300;
      j_valid_i = 1'b1; jr_valid_i = 1'b1;
      step(); clr();
      chk_fetch("br_over_all", 32'h3300, 2'd1);
      wait_valid("j");
      j_valid_i = 1'b1;
      step(); clr();
      chk_fetch("j_only", 32'h3100, 2'd2);
      wait_valid("seq2");
      if_ready_i = 1'b1;
      step();
      if_ready_i = 1'b0;
      chk_fetch("seq_after_j", 32'h3104, 2'd0);

      // redirect during a 3-cycle fetch: stale addr held until ack
      exp_req_q.push_back(32'h3010);
      exp_req_q.push_back(32'h3040);
      exp_req_q.push_back(32'h3044);
      exp_xfer_q.push_back(32'h3040);
      wait_valid("to3010");
      lat = 2;
      jr_valid_i = 1'b1; jr_target_i = 32'h3010;
      step(); clr();
      chk_fetch("f3010", 32'h3010, 2'd3);
      br_taken_i = 1'b1; br_target_i = 32'h3040;
      step(); clr();
      chk_fetch("drop_c2", 32'h3010, 2'd1);
      step();
      chk_fetch("drop_c3", 32'h3010, 2'd1);
      step();
      chk_fetch("f3040", 32'h3040, 2'd1);
      wait_valid("h3040");
      if_ready_i = 1'b1;
      step();
      if_ready_i = 1'b0;

      // two redirects while in DROP: latest wins
      exp_req_q.push_back(32'h3020);
      exp_req_q.push_back(32'h3080);
      exp_xfer_q.push_back(32'h3080);
      wait_valid("h3044");
      lat = 3;
      jr_valid_i = 1'b1; jr_target_i = 32'h3020;
      step(); clr();
      br_taken_i = 1'b1; br_target_i = 32'h3060;
      step(); clr();
      br_taken_i = 1'b1; br_target_i = 32'h3040;
      step(); clr();
      jr_valid_i = 1'b1; jr_target_i = 32'h3080;
      step(); clr();
      chk_fetch("drop_c4", 32'h3020, 2'd3);
      step();
      chk_fetch("f3080", 32'h3080, 2'd3);
      wait_valid("h3080");
      if_ready_i = 1'b1;
      step();
      if_ready_i = 1'b0;

      // async reset with the 3084 request outstanding
      step();
      rst_n = 1'b0;
      #1;
      check_reset("mid");
      step();
      step();
      lat = 0;
      exp_req_q.push_back(32'h3000);
      exp_req_q.push_back(32'h3004);
      exp_xfer_q.push_back(32'h3000);
      rst_n = 1'b1;
      wait_valid("post_rst");
      if_ready_i = 1'b1;
      step();
      if_ready_i = 1'b0;
      repeat (4) step();

      check("req_q_left", exp_req_q.size(), 32'd0);
      check("xfer_q_left", exp_xfer_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Instruction-fetch controller that owns the architectural PC and sequences fetches into instruction memory. It arbitrates redirect requests (branch from EX, jump/jr from ID) against sequential PC+4, runs a one-outstanding-request req/ack handshake with imem, and hands instructions to ID through a valid/ready interface. It sits at the front of the pipeline and encodes its next-PC selection as PCSrc (0 seq, 1 branch, 2 jump, 3 jr).

## Interface
- RESET_PC, 32'h0000_3000, first fetch address after reset

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- br_taken_i  in  1  EX branch taken (redirect)
- br_target_i  in  32  branch target
- j_valid_i  in  1  ID j/jal redirect
- j_index_i  in  26  instr_index field
- id_pc_hi_i  in  4  PC[31:28] of the jump instruction in ID
- jr_valid_i  in  1  ID jr redirect
- jr_target_i  in  32  register target
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address (== current PC)
- imem_ack_i  in  1  request complete, data valid this cycle
- imem_rdata_i  in  32  fetched word
- if_valid_o  out  1  instruction available to ID
- if_ready_i  in  1  ID accepts
- if_instr_o  out  32  held instruction
- if_pc_o  out  32  PC of held instruction
- if_pc_plus4_o  out  32  if_pc_o + 4
- pc_src_o  out  2  PCSrc code of the last PC update (registered)

## Operation
- Redirect priority: br_taken_i > jr_valid_i > j_valid_i. Targets: branch = br_target_i; jr = jr_target_i; jump = {id_pc_hi_i, j_index_i, 2'b00}. All arithmetic is 32-bit, wrapping (PC 32'hFFFF_FFFC + 4 = 0). No alignment check.
- Redirect = any of the three valids high at a clock edge. It replaces PC and discards any instruction held or in flight in this block. An instruction transferred to ID in the redirect cycle is ID's responsibility to flush.
- States: IDLE, FETCH, HOLD, DROP.
  - IDLE: reset state. Next edge goes to FETCH. A redirect here loads PC.
  - FETCH: imem_req_o=1. Ack with no redirect: latch rdata/PC and go to HOLD. Ack with redirect: discard the data, PC<=target, stay in FETCH. Redirect without ack: PC<=target, go to DROP.
  - DROP: imem_req_o=1 with the stale address held (the request must stay stable until ack). A further redirect updates PC (latest wins). Ack: discard the data, go to FETCH.
  - HOLD: if_valid_o=1. With if_ready_i and no redirect: PC<=PC+4, pc_src_o<=0, go to FETCH. With a redirect, regardless of ready: PC<=target, go to FETCH.
- pc_src_o is updated on every PC load: 0 seq, 1 branch, 2 jump, 3 jr.

## Timing
- Reset values: PC=RESET_PC, state=IDLE, imem_req_o=0, imem_addr_o=RESET_PC, if_valid_o=0, if_instr_o=0, if_pc_o=0, if_pc_plus4_o=4, pc_src_o=0.
- All outputs are registered or decoded from state only. There is no combinational path from the *_i inputs to any output.
- Ack is sampled on the edge that ends a req-high cycle. A zero-wait ack (ack in the first req cycle) is legal.
- Latency: from req cycle N with ack in N, if_valid_o rises in N+1. Peak throughput is 1 instruction per 2 cycles.
- Redirect to new request: the next cycle, or the cycle after the pending ack when in DROP.
- Reset asserted mid-request: return to IDLE immediately and drop the outstanding request. imem must tolerate the abandoned request.

## Structure
- Shared package cpu_pkg:
  - state enum (IDLE/FETCH/HOLD/DROP)
  - PCSrc constants PC_SEQ=2'd0, PC_BR=2'd1, PC_J=2'd2, PC_JR=2'd3
  - default RESET_PC
- One combinational sub-module, pc_next_sel. It performs priority resolution plus target/PC+4 computation and outputs {redirect, next_pc, pc_src}. The FSM, PC register and holding register stay in the top.

## Test plan
- Reset, then a zero-wait imem -> first req addr 32'h3000. if_valid_o rises one cycle after the ack, with if_pc_o=32'h3000 and if_pc_plus4_o=32'h3004. With ready held high, the following fetches are 32'h3004 and 32'h3008, one every 2 cycles.
- br_taken_i with target 32'h3100 while in HOLD with if_ready_i=0 -> held instr dropped, next req addr 32'h3100, pc_src_o=1.
- j_valid_i with j_index_i=26'h0000C40, id_pc_hi_i=4'h0, and jr_valid_i with target 32'h3200, in the same cycle -> jr wins: next addr 32'h3200, pc_src_o=3. Add br_taken_i in the same cycle -> branch wins.
- Redirect to 32'h3040 during a 3-cycle-latency fetch of 32'h3010 -> req stays high with addr 32'h3010 until the ack, the data is never presented, then a req for 32'h3040 follows.
- Two redirects (32'h3040, then 32'h3080) while in DROP -> only 32'h3080 is fetched.
- rst_n pulsed low while req is outstanding -> outputs return to their reset values asynchronously, and the first fetch after release is again 32'h3000.
